// File: rtl/mac_neuron_sequencer.sv
// Dot-product sequencer for one MAC slice: fetches N input/weight pairs from two RAMs,
// streams them into the MAC, waits out its latency and rescales the sum with saturation.
module mac_neuron_sequencer #(
  parameter int DATA_W      = 16,
  parameter int FRAC_W      = 8,
  parameter int ACC_W       = 40,
  parameter int ADDR_W      = 10,
  parameter int MAC_LATENCY = 4
) (
  input  logic              clk,
  input  logic              sclr,
  input  logic              start,
  input  logic [ADDR_W-1:0] len,
  input  logic [ADDR_W-1:0] x_base,
  input  logic [ADDR_W-1:0] w_base,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              mem_en,
  output logic [ADDR_W-1:0] x_addr,
  output logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] x_data,
  input  logic [DATA_W-1:0] w_data,
  output logic              mac_ce,
  output logic              mac_sclr,
  output logic              mac_bypass,
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_b,
  input  logic [ACC_W-1:0]  mac_s
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam int DCNT_W = $clog2(MAC_LATENCY + 1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] cnt;
  logic [DCNT_W-1:0] dcnt;
  logic              bypass_p0;

  // Arithmetic shift truncates toward -inf; out-of-range values clamp to the DATA_W limits.
  function automatic logic [DATA_W-1:0] sat_rescale(input logic signed [ACC_W-1:0] s);
    logic signed [ACC_W-1:0] t;
    logic signed [ACC_W-1:0] max_v;
    logic signed [ACC_W-1:0] min_v;
    t     = s >>> FRAC_W;
    max_v = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    min_v = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    if (t > max_v)
      return {1'b0, {(DATA_W-1){1'b1}}};
    else if (t < min_v)
      return {1'b1, {(DATA_W-1){1'b0}}};
    else
      return t[DATA_W-1:0];
  endfunction

  assign mac_sclr = sclr;
  assign mac_a    = mac_ce ? x_data : '0;
  assign mac_b    = mac_ce ? w_data : '0;

  always_ff @(posedge clk) begin
    if (sclr) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
      mem_en     <= 1'b0;
      x_addr     <= '0;
      w_addr     <= '0;
      mac_ce     <= 1'b0;
      mac_bypass <= 1'b0;
      bypass_p0  <= 1'b0;
      cnt        <= '0;
      dcnt       <= '0;
    end else begin
      done       <= 1'b0;
      // Stage p0 -> p1: RAM read cycle becomes the MAC term cycle.
      mac_ce     <= mem_en;
      mac_bypass <= bypass_p0;
      bypass_p0  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (len == '0) begin
              result <= '0;
              done   <= 1'b1;
              state  <= S_DONE;
            end else begin
              state     <= S_FETCH;
              mem_en    <= 1'b1;
              x_addr    <= x_base;
              w_addr    <= w_base;
              cnt       <= len - 1'b1;
              bypass_p0 <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          if (cnt == '0) begin
            mem_en <= 1'b0;
            dcnt   <= DCNT_W'(MAC_LATENCY);
            state  <= S_DRAIN;
          end else begin
            cnt    <= cnt - 1'b1;
            x_addr <= x_addr + 1'b1;
            w_addr <= w_addr + 1'b1;
          end
        end
        S_DRAIN: begin
          if (dcnt == '0) begin
            result <= sat_rescale($signed(mac_s));
            done   <= 1'b1;
            state  <= S_DONE;
          end else begin
            dcnt <= dcnt - 1'b1;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_neuron_sequencer.sv
// Self-checking bench for mac_neuron_sequencer with RAM and MAC behavioural models.
module tb_mac_neuron_sequencer;
  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;
  localparam int ACC_W  = 40;
  localparam int ADDR_W = 10;
  localparam int LAT    = 4;

  logic              clk = 1'b0;
  logic              sclr = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] len = '0;
  logic [ADDR_W-1:0] x_base = '0;
  logic [ADDR_W-1:0] w_base = '0;
  logic              busy, done, mem_en, mac_ce, mac_sclr, mac_bypass;
  logic [DATA_W-1:0] result, x_data, w_data, mac_a, mac_b;
  logic [ADDR_W-1:0] x_addr, w_addr;
  logic [ACC_W-1:0]  mac_s;

  int checks = 0;
  int errors = 0;

  logic [15:0] xmem [1024];
  logic [15:0] wmem [1024];

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] pipe [LAT-1];
  logic signed [ACC_W-1:0] prod;

  mac_neuron_sequencer #(
    .DATA_W(DATA_W), .FRAC_W(FRAC_W), .ACC_W(ACC_W), .ADDR_W(ADDR_W), .MAC_LATENCY(LAT)
  ) dut (
    .clk(clk), .sclr(sclr), .start(start), .len(len), .x_base(x_base), .w_base(w_base),
    .busy(busy), .done(done), .result(result), .mem_en(mem_en), .x_addr(x_addr),
    .w_addr(w_addr), .x_data(x_data), .w_data(w_data), .mac_ce(mac_ce),
    .mac_sclr(mac_sclr), .mac_bypass(mac_bypass), .mac_a(mac_a), .mac_b(mac_b),
    .mac_s(mac_s)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      x_data <= xmem[x_addr];
      w_data <= wmem[w_addr];
    end
  end

  assign prod  = $signed(mac_a) * $signed(mac_b);
  assign mac_s = pipe[LAT-2];

  always @(posedge clk) begin
    if (mac_sclr) begin
      acc <= '0;
      for (int k = 0; k < LAT-1; k++) pipe[k] <= '0;
    end else begin
      if (mac_ce) acc <= mac_bypass ? prod : acc + prod;
      pipe[0] <= acc;
      for (int k = 1; k < LAT-1; k++) pipe[k] <= pipe[k-1];
    end
  end

  function automatic logic [15:0] ref_dot(input int n, input int xb, input int wb);
    longint sum;
    longint t;
    sum = 0;
    for (int i = 0; i < n; i++)
      sum += longint'($signed(xmem[(xb+i)%1024])) * longint'($signed(wmem[(wb+i)%1024]));
    t = sum >>> FRAC_W;
    if (t > 32767) return 16'h7FFF;
    if (t < -32768) return 16'h8000;
    return t[15:0];
  endfunction

  // Run observation results
  int n_mem, first_mem, last_mem, n_ce, n_byp, byp_cyc, done_cyc, addr_err, data_err, busy_err;
  logic [15:0] res;

  task automatic do_run(input int n, input int xb, input int wb, input bit noise);
    int cyc;
    n_mem = 0; first_mem = -1; last_mem = -1; n_ce = 0; n_byp = 0; byp_cyc = -1;
    done_cyc = -1; addr_err = 0; data_err = 0; busy_err = 0; res = 'x;
    @(posedge clk); #2;
    start = 1'b1; len = ADDR_W'(n); x_base = ADDR_W'(xb); w_base = ADDR_W'(wb);
    cyc = 0;
    while (cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (mem_en) begin
        if (x_addr !== ADDR_W'((xb + n_mem) % 1024) || w_addr !== ADDR_W'((wb + n_mem) % 1024))
          addr_err++;
        if (first_mem < 0) first_mem = cyc;
        last_mem = cyc;
        n_mem++;
      end
      if (mac_ce) begin
        if (mac_a !== xmem[(xb+n_ce)%1024] || mac_b !== wmem[(wb+n_ce)%1024]) data_err++;
        if (mac_bypass) begin n_byp++; byp_cyc = cyc; end
        n_ce++;
      end else if (mac_a !== '0 || mac_b !== '0 || mac_bypass !== 1'b0) begin
        data_err++;
      end
      if (busy !== 1'b1) busy_err++;
      if (done === 1'b1) begin
        done_cyc = cyc;
        res = result;
        start = 1'b0;
        break;
      end
      if (noise) begin
        start = 1'($urandom);
        len = ADDR_W'($urandom);
        x_base = ADDR_W'($urandom);
        w_base = ADDR_W'($urandom);
      end
    end
  endtask

  task automatic load_basic();
    xmem[100] = 16'h0100; xmem[101] = 16'h0200; xmem[102] = 16'hFF00;
    wmem[200] = 16'h0200; wmem[201] = 16'h0080; wmem[202] = 16'h0100;
  endtask

  task automatic test_reset();
    sclr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start = 1'($urandom); len = ADDR_W'($urandom);
      @(posedge clk); #1;
      checks++;
      if ({busy, done, mem_en, mac_ce, mac_bypass, result, x_addr, w_addr, mac_a, mac_b} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got busy=%b done=%b mem_en=%b mac_ce=%b byp=%b result=%h xa=%h wa=%h a=%h b=%h, want all 0",
                 busy, done, mem_en, mac_ce, mac_bypass, result, x_addr, w_addr, mac_a, mac_b);
      end
      checks++;
      if (mac_sclr !== 1'b1) begin errors++; $display("FAIL reset_mac_sclr_high: got %b want 1", mac_sclr); end
    end
    start = 1'b0; sclr = 1'b0; #1;
    checks++;
    if (mac_sclr !== 1'b0) begin errors++; $display("FAIL reset_mac_sclr_low: got %b want 0", mac_sclr); end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || mem_en !== 1'b0) begin
      errors++; $display("FAIL reset_idle: busy=%b done=%b mem_en=%b want 0 0 0", busy, done, mem_en);
    end
  endtask

  task automatic test_basic();
    load_basic();
    do_run(3, 100, 200, 1'b0);
    checks++; if (res !== 16'h0200) begin errors++; $display("FAIL basic_result: got %h want 0200", res); end
    checks++; if (done_cyc !== 9) begin errors++; $display("FAIL basic_done_cycle: got %0d want 9", done_cyc); end
    checks++;
    if (n_mem !== 3 || first_mem !== 1 || last_mem !== 3) begin
      errors++; $display("FAIL basic_mem_en: got n=%0d first=%0d last=%0d want 3 1 3", n_mem, first_mem, last_mem);
    end
    checks++;
    if (n_ce !== 3 || n_byp !== 1 || byp_cyc !== 2) begin
      errors++; $display("FAIL basic_mac_ce: got n_ce=%0d n_byp=%0d byp_cyc=%0d want 3 1 2", n_ce, n_byp, byp_cyc);
    end
    checks++;
    if (addr_err !== 0 || data_err !== 0 || busy_err !== 0) begin
      errors++; $display("FAIL basic_stream: got addr_err=%0d data_err=%0d busy_err=%0d want 0", addr_err, data_err, busy_err);
    end
  endtask

  task automatic test_back_to_back();
    xmem[300] = 16'h0300; wmem[400] = 16'h0100;
    do_run(1, 300, 400, 1'b1);
    checks++; if (res !== 16'h0300) begin errors++; $display("FAIL b2b_result: got %h want 0300", res); end
    checks++; if (done_cyc !== 7) begin errors++; $display("FAIL b2b_done_cycle: got %0d want 7", done_cyc); end
    checks++;
    if (n_byp !== 1 || byp_cyc !== 2 || data_err !== 0) begin
      errors++; $display("FAIL b2b_bypass: got n_byp=%0d byp_cyc=%0d data_err=%0d want 1 2 0", n_byp, byp_cyc, data_err);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== 16'h0300) begin
      errors++; $display("FAIL b2b_after_done: got done=%b busy=%b result=%h want 0 0 0300", done, busy, result);
    end
  endtask

  task automatic test_saturation();
    xmem[500] = 16'h7FFF; xmem[501] = 16'h7FFF; wmem[600] = 16'h7FFF; wmem[601] = 16'h7FFF;
    do_run(2, 500, 600, 1'b0);
    checks++; if (res !== 16'h7FFF) begin errors++; $display("FAIL sat_pos: got %h want 7fff", res); end
    xmem[510] = 16'h8000; xmem[511] = 16'h8000; wmem[610] = 16'h7FFF; wmem[611] = 16'h7FFF;
    do_run(2, 510, 610, 1'b0);
    checks++; if (res !== 16'h8000) begin errors++; $display("FAIL sat_neg: got %h want 8000", res); end
  endtask

  task automatic test_edges();
    logic [15:0] exp;
    do_run(0, 5, 6, 1'b0);
    checks++;
    if (done_cyc !== 1 || res !== 16'h0000 || n_mem !== 0 || n_ce !== 0) begin
      errors++; $display("FAIL len0: got done_cyc=%0d res=%h n_mem=%0d n_ce=%0d want 1 0000 0 0", done_cyc, res, n_mem, n_ce);
    end
    xmem[1022] = 16'h0100; xmem[1023] = 16'h0180; xmem[0] = 16'hFE00; xmem[1] = 16'h0040;
    wmem[1021] = 16'h0300; wmem[1022] = 16'h0100; wmem[1023] = 16'h0200; wmem[0] = 16'hFF80;
    exp = ref_dot(4, 1022, 1021);
    do_run(4, 1022, 1021, 1'b0);
    checks++;
    if (addr_err !== 0 || n_mem !== 4) begin
      errors++; $display("FAIL wrap_addr: got addr_err=%0d n_mem=%0d want 0 4", addr_err, n_mem);
    end
    checks++; if (res !== exp) begin errors++; $display("FAIL wrap_result: got %h want %h", res, exp); end
  endtask

  task automatic test_reset_mid_run();
    int saw_done;
    @(posedge clk); #2;
    start = 1'b1; len = 10'd5; x_base = 10'd100; w_base = 10'd200;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL midrst_fetch1: got mem_en=%b want 1", mem_en); end
    @(posedge clk); #1;
    sclr = 1'b1;
    @(posedge clk); #1;
    sclr = 1'b0;
    checks++;
    if (mem_en !== 1'b0 || mac_ce !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL midrst_abort: got mem_en=%b mac_ce=%b busy=%b want 0 0 0", mem_en, mac_ce, busy);
    end
    saw_done = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done++;
    end
    checks++; if (saw_done !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d done pulses want 0", saw_done); end
    load_basic();
    do_run(3, 100, 200, 1'b0);
    checks++;
    if (res !== 16'h0200 || done_cyc !== 9) begin
      errors++; $display("FAIL midrst_rerun: got res=%h done_cyc=%0d want 0200 9", res, done_cyc);
    end
  endtask

  task automatic test_random();
    int n, xb, wb;
    logic [15:0] exp;
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 1024; i++) begin
        if (r % 2 == 0) begin
          xmem[i] = 16'($urandom_range(0, 2047)) - 16'd1024;
          wmem[i] = 16'($urandom_range(0, 2047)) - 16'd1024;
        end else begin
          xmem[i] = 16'($urandom);
          wmem[i] = 16'($urandom);
        end
      end
      n  = $urandom_range(1, 24);
      xb = $urandom_range(0, 1023);
      wb = $urandom_range(0, 1023);
      exp = ref_dot(n, xb, wb);
      do_run(n, xb, wb, 1'($urandom));
      checks++;
      if (res !== exp || done_cyc !== n + 2 + LAT) begin
        errors++; $display("FAIL rand_run%0d: got res=%h done_cyc=%0d want %h %0d", r, res, done_cyc, exp, n + 2 + LAT);
      end
      checks++;
      if (addr_err !== 0 || data_err !== 0 || n_mem !== n || n_ce !== n || n_byp !== 1) begin
        errors++; $display("FAIL rand_stream%0d: got addr_err=%0d data_err=%0d n_mem=%0d n_ce=%0d n_byp=%0d want 0 0 %0d %0d 1",
                           r, addr_err, data_err, n_mem, n_ce, n_byp, n, n);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin xmem[i] = '0; wmem[i] = '0; end
    test_reset();
    test_basic();
    test_back_to_back();
    test_saturation();
    test_edges();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
